// File: rtl/iomem_copy_master_if.sv
// rtl/iomem_copy_master_if.sv - PicoRV32 native memory bus bundle used by the copy master
`timescale 1ns/1ps

interface iomem_copy_master_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/iomem_copy_master.sv
// rtl/iomem_copy_master.sv - word-by-word read-then-write copy engine on the iomem bus
`timescale 1ns/1ps

module iomem_copy_master #(
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [31:0]          i_cmd_src,
  input  logic [31:0]          i_cmd_dst,
  input  logic [LEN_WIDTH-1:0] i_cmd_len,
  input  logic                 i_abort,
  iomem_copy_master_if.master  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [LEN_WIDTH-1:0] o_words_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RGAP,
    S_WR,
    S_WGAP,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [31:0]          ADDR_MSK = 32'hFFFF_FFFC;
  localparam logic [31:0]          WORD_INC = 32'd4;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_data;
  logic [31:0]          r_tmo;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [LEN_WIDTH-1:0] r_words_done;
  logic                 w_accept;
  logic                 w_in_xfer;
  logic                 w_tmo_hit;

  assign w_accept  = i_cmd_valid && (r_state == S_IDLE);
  assign w_in_xfer = (r_state == S_RD) || (r_state == S_WR);
  // Terminal count is the TIMEOUT_CYCLES-th stalled cycle; a ready in that same cycle still wins.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_data       <= '0;
      r_tmo        <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src        <= i_cmd_src & ADDR_MSK;
        r_dst        <= i_cmd_dst & ADDR_MSK;
        r_remaining  <= i_cmd_len;
        r_words_done <= '0;
      end
      if ((r_state == S_RD) && bus.mem_ready) begin
        r_data <= bus.mem_rdata;
        r_src  <= r_src + WORD_INC;
      end
      if ((r_state == S_WR) && bus.mem_ready) begin
        r_dst        <= r_dst + WORD_INC;
        r_remaining  <= r_remaining - LEN_ONE;
        r_words_done <= r_words_done + LEN_ONE;
      end
      // Gap/idle states always precede RD and WR, so clearing here restarts the count per request.
      if (!w_in_xfer) begin
        r_tmo <= '0;
      end else if (!bus.mem_ready) begin
        r_tmo <= r_tmo + 32'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_next = (i_cmd_len != '0) ? S_RD : S_FIN;
        end
      end
      S_RD: begin
        if (bus.mem_ready) begin
          w_next = S_RGAP;
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_RGAP: w_next = S_WR;
      S_WR: begin
        if (bus.mem_ready) begin
          w_next = S_WGAP;
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_WGAP: begin
        w_next = ((r_remaining == '0) || i_abort) ? S_FIN : S_RD;
      end
      S_FIN:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready   = (r_state == S_IDLE);
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_FIN);
    o_err         = (r_state == S_ERR);
    o_words_done  = r_words_done;
    bus.mem_valid = w_in_xfer;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = 4'h0;
    if (r_state == S_RD) begin
      bus.mem_addr = r_src;
    end else if (r_state == S_WR) begin
      bus.mem_addr  = r_dst;
      bus.mem_wdata = r_data;
      bus.mem_wstrb = 4'hF;
    end
  end

endmodule

// File: tb/tb_iomem_copy_master.sv
// tb/tb_iomem_copy_master.sv - scoreboard bench for the iomem copy master
`timescale 1ns/1ps

module tb_iomem_copy_master;
  localparam int LW  = 16;
  localparam int TMO = 8;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic [31:0]   i_cmd_src = '0;
  logic [31:0]   i_cmd_dst = '0;
  logic [LW-1:0] i_cmd_len = '0;
  logic          i_abort = 1'b0;
  logic          o_cmd_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [LW-1:0] o_words_done;

  iomem_copy_master_if bus ();

  iomem_copy_master #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_src    (i_cmd_src),
    .i_cmd_dst    (i_cmd_dst),
    .i_cmd_len    (i_cmd_len),
    .i_abort      (i_abort),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_words_done (o_words_done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  txn_t        exp_q[$];
  txn_t        sb_e;
  logic [31:0] sb_got;
  logic [31:0] mem [logic [31:0]];
  int          max_wait = 0;
  int          wcnt = 0;
  int          wtgt = 0;
  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = '0;
  int          valid_cycles = 0;
  int          vrun = 0;
  int          vrun_max = 0;
  int          stab_viol = 0;
  int          gap_viol = 0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Responder: ready comes wtgt+1 cycles after valid is first seen.
  always @(posedge clk) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      wcnt          <= 0;
      wtgt          <= 0;
    end else if (bus.mem_valid && !bus.mem_ready) begin
      if (stall_en && (bus.mem_wstrb == 4'hF) && (bus.mem_addr == stall_addr)) begin
        bus.mem_ready <= 1'b0;
      end else if (wcnt >= wtgt) begin
        bus.mem_ready <= 1'b1;
        if (bus.mem_wstrb == 4'h0) bus.mem_rdata <= rd_model(bus.mem_addr);
        else mem[bus.mem_addr] = bus.mem_wdata;
        wcnt <= 0;
        wtgt <= (max_wait == 0) ? 0 : $urandom_range(0, max_wait);
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.mem_ready <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
      vrun    = 0;
    end else begin
      if (bus.mem_valid) begin
        valid_cycles++;
        vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else begin
        vrun = 0;
      end
      if (bus.mem_valid && p_valid && !p_ready &&
          (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wdata || bus.mem_wstrb !== p_wstrb))
        stab_viol++;
      if (bus.mem_valid && p_valid && p_ready) gap_viol++;
      if (bus.mem_valid && bus.mem_ready) begin
        n_tests++;
        sb_got = (bus.mem_wstrb == 4'h0) ? bus.mem_rdata : bus.mem_wdata;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got addr=%h strb=%h data=%h, required no transaction",
                   bus.mem_addr, bus.mem_wstrb, sb_got);
        end else begin
          sb_e = exp_q.pop_front();
          if (bus.mem_addr !== sb_e.addr || bus.mem_wstrb !== sb_e.strb || sb_got !== sb_e.data) begin
            n_fail++;
            $display("FAIL sb_txn: got addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                     bus.mem_addr, bus.mem_wstrb, sb_got, sb_e.addr, sb_e.strb, sb_e.data);
          end
        end
      end
      p_valid = bus.mem_valid;
      p_ready = bus.mem_ready;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
      p_wstrb = bus.mem_wstrb;
    end
  end

  task automatic preload(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int nfull, input bit extra_rd);
    txn_t t;
    for (int i = 0; i < nfull; i++) begin
      t.addr = s + 32'(4 * i); t.strb = 4'h0; t.data = rd_model(t.addr);
      exp_q.push_back(t);
      t.addr = d + 32'(4 * i); t.strb = 4'hF;
      exp_q.push_back(t);
    end
    if (extra_rd) begin
      t.addr = s + 32'(4 * nfull); t.strb = 4'h0; t.data = rd_model(t.addr);
      exp_q.push_back(t);
    end
  endtask

  task automatic issue_cmd(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n);
    @(negedge clk);
    i_cmd_src = s; i_cmd_dst = d; i_cmd_len = n; i_cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (o_cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit gd, output bit ge, output int lat);
    gd = 0; ge = 0; lat = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_done) begin gd = 1; break; end
      if (o_err) begin ge = 1; break; end
      lat++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", o_cmd_ready); end
    n_tests++;
    if ({o_busy, o_done, o_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/err=%b, required 000", {o_busy, o_done, o_err});
    end
    n_tests++;
    if (o_words_done !== '0) begin n_fail++; $display("FAIL reset_words_done: got %0d, required 0", o_words_done); end
    n_tests++;
    if ({bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got valid=%b strb=%h addr=%h wdata=%h, required all 0",
                         bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_copy4();
    logic [31:0] s = 32'h0300_0000, d = 32'h0300_0100;
    logic [31:0] src_val [4];
    bit gd, ge; int lat;
    max_wait = 0;
    preload(s, 4);
    for (int i = 0; i < 4; i++) src_val[i] = mem[s + 32'(4 * i)];
    push_copy(s, d, 4, 0);
    issue_cmd(s, d, 16'd4);
    wait_end(200, gd, ge, lat);
    n_tests++;
    if (!gd || ge) begin n_fail++; $display("FAIL copy4_end: got done=%b err=%b, required done=1 err=0", gd, ge); end
    n_tests++;
    if (lat != 24) begin n_fail++; $display("FAIL copy4_latency: got %0d, required 24", lat); end
    n_tests++;
    if (o_words_done !== 16'd4) begin n_fail++; $display("FAIL copy4_words_done: got %0d, required 4", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL copy4_sb_left: got %0d pending, required 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_model(d + 32'(4 * i)) !== src_val[i]) begin
        n_fail++; $display("FAIL copy4_dst_word%0d: got %h, required %h", i, rd_model(d + 32'(4 * i)), src_val[i]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL copy4_done_pulse: got done=%b busy=%b, required 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_len0();
    bit gd, ge; int lat; int v0;
    v0 = valid_cycles;
    issue_cmd(32'h0300_0000, 32'h0300_0100, 16'd0);
    wait_end(20, gd, ge, lat);
    n_tests++;
    if (!gd || ge || lat != 0) begin
      n_fail++; $display("FAIL len0_done: got done=%b err=%b lat=%0d, required 1 0 0", gd, ge, lat);
    end
    n_tests++;
    if (o_words_done !== '0) begin n_fail++; $display("FAIL len0_words_done: got %0d, required 0", o_words_done); end
    n_tests++;
    if (valid_cycles != v0) begin n_fail++; $display("FAIL len0_no_bus: got %0d valid cycles, required 0", valid_cycles - v0); end
  endtask

  task automatic test_random_wait();
    logic [31:0] s = 32'h0300_0400, d = 32'h0300_0800;
    bit gd, ge; int lat; int sv0, gv0;
    sv0 = stab_viol; gv0 = gap_viol;
    max_wait = TMO - 2;
    preload(s, 6);
    push_copy(s, d, 6, 0);
    issue_cmd(s, d, 16'd6);
    wait_end(1000, gd, ge, lat);
    max_wait = 0;
    n_tests++;
    if (!gd || ge) begin n_fail++; $display("FAIL rwait_end: got done=%b err=%b, required done=1 err=0", gd, ge); end
    n_tests++;
    if (o_words_done !== 16'd6) begin n_fail++; $display("FAIL rwait_words_done: got %0d, required 6", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rwait_sb_left: got %0d pending, required 0", exp_q.size()); end
    n_tests++;
    if (stab_viol != sv0) begin n_fail++; $display("FAIL rwait_stable: got %0d unstable cycles, required 0", stab_viol - sv0); end
    n_tests++;
    if (gap_viol != gv0) begin n_fail++; $display("FAIL rwait_gap: got %0d back-to-back requests, required 0", gap_viol - gv0); end
  endtask

  task automatic test_timeout();
    logic [31:0] s = 32'h0300_1000, d = 32'h0300_1100;
    bit gd, ge; int lat;
    preload(s, 5);
    stall_addr = d + 32'd8;
    stall_en   = 1'b1;
    vrun_max   = 0;
    push_copy(s, d, 2, 1);
    issue_cmd(s, d, 16'd5);
    wait_end(300, gd, ge, lat);
    stall_en = 1'b0;
    n_tests++;
    if (gd || !ge) begin n_fail++; $display("FAIL tmo_end: got done=%b err=%b, required done=0 err=1", gd, ge); end
    n_tests++;
    if (vrun_max != TMO) begin n_fail++; $display("FAIL tmo_valid_run: got %0d, required %0d", vrun_max, TMO); end
    n_tests++;
    if (o_words_done !== 16'd2) begin n_fail++; $display("FAIL tmo_words_done: got %0d, required 2", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL tmo_sb_left: got %0d pending, required 0", exp_q.size()); end
    @(negedge clk);
    n_tests++;
    if (o_err !== 1'b0 || o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL tmo_after: got err=%b done=%b cmd_ready=%b, required 0 0 1", o_err, o_done, o_cmd_ready);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] s = 32'hFFFF_FFF8, d = 32'h0300_2000;
    bit gd, ge; int lat;
    preload(s, 3);
    push_copy(s, d, 3, 0);
    issue_cmd(s, d, 16'd3);
    wait_end(200, gd, ge, lat);
    n_tests++;
    if (!gd || ge) begin n_fail++; $display("FAIL wrap_end: got done=%b err=%b, required done=1 err=0", gd, ge); end
    n_tests++;
    if (o_words_done !== 16'd3) begin n_fail++; $display("FAIL wrap_words_done: got %0d, required 3", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_sb_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    logic [31:0] s = 32'h0300_3000, d = 32'h0300_3100;
    bit gd, ge; int lat;
    i_abort = 1'b1;
    repeat (3) @(negedge clk);
    i_abort = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", o_busy, o_done);
    end
    preload(s, 5);
    push_copy(s, d, 2, 0);
    issue_cmd(s, d, 16'd5);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.mem_valid && bus.mem_wstrb == 4'h0 && bus.mem_addr == s + 32'd4) break;
    end
    i_abort = 1'b1;
    wait_end(200, gd, ge, lat);
    i_abort = 1'b0;
    n_tests++;
    if (!gd || ge) begin n_fail++; $display("FAIL abort_end: got done=%b err=%b, required done=1 err=0", gd, ge); end
    n_tests++;
    if (o_words_done !== 16'd2) begin n_fail++; $display("FAIL abort_words_done: got %0d, required 2", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_sb_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s = 32'h0300_4000, d = 32'h0300_4100;
    preload(s, 4);
    push_copy(s, d, 4, 0);
    issue_cmd(s, d, 16'd4);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.mem_valid && bus.mem_wstrb == 4'hF && bus.mem_addr == d + 32'd4) break;
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.mem_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got valid=%b busy=%b, required 0 0", bus.mem_valid, o_busy);
    end
    n_tests++;
    if (o_words_done !== '0 || o_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_regs: got words_done=%0d cmd_ready=%b, required 0 1", o_words_done, o_cmd_ready);
    end
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1 = 32'h0300_5000, d1 = 32'h0300_5100;
    logic [31:0] s2 = 32'h0300_6000, d2 = 32'h0300_6100;
    bit gd, ge; int lat;
    preload(s1, 2);
    preload(s2, 3);
    push_copy(s1, d1, 2, 0);
    push_copy(s2, d2, 3, 0);
    issue_cmd(s1, d1, 16'd2);
    i_cmd_src = s2; i_cmd_dst = d2; i_cmd_len = 16'd3; i_cmd_valid = 1'b1;
    wait_end(200, gd, ge, lat);
    n_tests++;
    if (!gd || o_words_done !== 16'd2) begin
      n_fail++; $display("FAIL b2b_first: got done=%b words_done=%0d, required 1 2", gd, o_words_done);
    end
    @(negedge clk);
    n_tests++;
    if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, required 1", o_cmd_ready); end
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    wait_end(200, gd, ge, lat);
    n_tests++;
    if (!gd || ge || lat != 18) begin
      n_fail++; $display("FAIL b2b_second: got done=%b err=%b lat=%0d, required 1 0 18", gd, ge, lat);
    end
    n_tests++;
    if (o_words_done !== 16'd3) begin n_fail++; $display("FAIL b2b_words_done: got %0d, required 3", o_words_done); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_copy4();
    test_len0();
    test_random_wait();
    test_timeout();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no summary after 500000 ns, required completion");
    $fatal(1);
  end

endmodule
